// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers: S-box, round constants, byte/word access.
// Byte 0 is the most significant byte of a 128-bit block (FIPS-197 order).
package aes_pkg;

  localparam int NR  = 10;
  localparam int KW  = 128;
  localparam int RKW = (NR + 1) * KW;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {b, 3'b000};
    return SBOX_TBL[11'd2047 - idx -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [KW-1:0] s, input logic [3:0] idx);
    logic [6:0] hi;
    hi = 7'd127 - {idx, 3'b000};
    return s[hi -: 8];
  endfunction

  function automatic logic [31:0] word_of(input logic [KW-1:0] s, input logic [1:0] idx);
    logic [6:0] hi;
    hi = 7'd127 - {idx, 5'b00000};
    return s[hi -: 32];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_shift_rows_ark.sv
// Final-round tail: ShiftRows on a column-major state followed by AddRoundKey.
module aes_shift_rows_ark
  import aes_pkg::*;
(
  input  logic [KW-1:0] state_in,
  input  logic [KW-1:0] round_key,
  output logic [KW-1:0] state_out
);

  logic [KW-1:0] shifted;

  // Output (row r, col c) takes input (row r, col (c+r) mod 4).
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8 * (4 * c + r) -: 8] = byte_of(state_in, 4'(4 * ((c + r) % 4) + r));
      end
    end
  end

  assign state_out = shifted ^ round_key;

endmodule

// File: rtl/aes128_key_sched_sr_ark.sv
// AES-128 key expansion (one round key per clock) plus the combinational
// ShiftRows/AddRoundKey path that reads the expanded key bus.
module aes128_key_sched_sr_ark
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KW-1:0]    key_in,
  output logic             busy,
  output logic             keys_valid,
  output logic [RKW-1:0]   round_keys,
  input  logic [KW-1:0]    state_in,
  input  logic [3:0]       round_sel,
  output logic [KW-1:0]    state_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic          load_key, step;
  logic [KW-1:0] prev_key, next_key, sel_key;
  logic [31:0]   temp, nw0, nw1, nw2, nw3;

  // Handshake: start is a request honoured only when busy is low; keys_valid
  // stays high until the next accepted start or a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      round_keys <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_key) round_keys[RKW-1 -: KW] <= key_in;
      for (int k = 1; k <= NR; k++) begin
        if (step && cnt == 4'(k)) round_keys[RKW - 1 - KW * k -: KW] <= next_key;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_key   = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_key   = 1'b1;
          cnt_next   = 4'd1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == 4'(NR)) begin
          cnt_next   = 4'd0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy       = (state == S_RUN);
  assign keys_valid = (state == S_DONE);

  always_comb begin
    prev_key = '0;
    sel_key  = '0;
    for (int k = 1; k <= NR; k++) begin
      if (cnt == 4'(k)) prev_key = round_keys[RKW - 1 - KW * (k - 1) -: KW];
    end
    // Selections beyond round 10 leave the key at zero.
    for (int k = 0; k <= NR; k++) begin
      if (round_sel == 4'(k)) sel_key = round_keys[RKW - 1 - KW * k -: KW];
    end
  end

  assign temp = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon(cnt), 24'h000000};
  assign nw0  = word_of(prev_key, 2'd0) ^ temp;
  assign nw1  = word_of(prev_key, 2'd1) ^ nw0;
  assign nw2  = word_of(prev_key, 2'd2) ^ nw1;
  assign nw3  = word_of(prev_key, 2'd3) ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  aes_shift_rows_ark u_sr_ark (
    .state_in  (state_in),
    .round_key (sel_key),
    .state_out (state_out)
  );

endmodule

// File: tb/tb_aes128_key_sched_sr_ark.sv
// Bench for aes128_key_sched_sr_ark: FIPS-197 vectors, random keys against a
// GF(2^8)-derived reference, restart/reset corner sequences.
module tb_aes128_key_sched_sr_ark;

  logic          clk;
  logic          rst;
  logic          start;
  logic [127:0]  key_in;
  logic          busy;
  logic          keys_valid;
  logic [1407:0] round_keys;
  logic [127:0]  state_in;
  logic [3:0]    round_sel;
  logic [127:0]  state_out;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  aes128_key_sched_sr_ark dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .round_keys (round_keys),
    .state_in   (state_in),
    .round_sel  (round_sel),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int j = 1; j < 256; j++) begin
        if (gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
      end
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand_ref(input logic [127:0] key);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] bus;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t = t ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int i = 0; i < 44; i++) bus[1407 - 32 * i -: 32] = w[i];
    return bus;
  endfunction

  function automatic logic [127:0] shift_rows_ref(input logic [127:0] s);
    logic [7:0]   m[4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[127 - 8 * (4 * c + r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127 - 8 * (4 * c + r) -: 8] = m[r][(c + r) % 4];
    return o;
  endfunction

  function automatic logic [127:0] rk_of(input logic [1407:0] bus, input int k);
    return bus[1407 - 128 * k -: 128];
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_keys(input logic [127:0] key, input string tag);
    logic [1407:0] e;
    logic [127:0]  x;
    e = expand_ref(key);
    for (int k = 0; k <= 10; k++) exp_q.push_back(rk_of(e, k));
    for (int k = 0; k <= 10; k++) begin
      x = exp_q.pop_front();
      chk($sformatf("%s_rk%0d", tag, k), rk_of(round_keys, k), x);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!keys_valid && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("busy_after_done", 128'(busy), 128'd0);
  endtask

  task automatic apply_sr(input logic [127:0] s, input logic [3:0] sel, input logic [127:0] exp,
                          input string name);
    @(negedge clk);
    state_in  = s;
    round_sel = sel;
    #1;
    chk(name, state_out, exp);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] r1;
    logic [127:0] r10;
  } kvec_t;

  typedef struct {
    logic [127:0] s;
    logic [3:0]   sel;
    logic [127:0] exp;
  } svec_t;

  kvec_t vec[2];
  svec_t svec[2];

  initial begin
    int lat, lat2;
    logic [127:0] ka, kb, ks, rs;
    logic [3:0]   rsel;
    logic [1407:0] e;

    vec[0].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vec[0].r1  = 128'ha0fafe1788542cb123a339392a6c7605;
    vec[0].r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vec[1].key = 128'h0;
    vec[1].r1  = 128'h62636363626363636263636362636363;
    vec[1].r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    svec[0].s   = 128'h00112233445566778899aabbccddeeff;
    svec[0].sel = 4'd11;
    svec[0].exp = 128'h0055aaff4499ee3388dd2277cc1166bb;
    svec[1].s   = 128'h00112233445566778899aabbccddeeff;
    svec[1].sel = 4'd10;
    svec[1].exp = 128'h0055aaff4499ee3388dd2277cc1166bb ^ 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1; start = 1'b0; key_in = '0; state_in = '0; round_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_valid", 128'(keys_valid), 128'd0);
    for (int k = 0; k <= 10; k++) chk($sformatf("reset_rk%0d", k), rk_of(round_keys, k), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Known-answer vectors
    for (int i = 0; i < 2; i++) begin
      do_start(vec[i].key);
      chk("busy_after_start", 128'(busy), 128'd1);
      wait_done(lat);
      chk("latency", 128'(lat), 128'd10);
      chk("kat_r0", rk_of(round_keys, 0), vec[i].key);
      chk("kat_r1", rk_of(round_keys, 1), vec[i].r1);
      chk("kat_r10", round_keys[127:0], vec[i].r10);
      check_keys(vec[i].key, $sformatf("kat%0d", i));
      if (i == 0) begin
        for (int j = 0; j < 2; j++) apply_sr(svec[j].s, svec[j].sel, svec[j].exp, "sr_kat");
      end
    end

    // Random keys and random ShiftRows/AddRoundKey traffic
    for (int i = 0; i < 3; i++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      do_start(ka);
      wait_done(lat);
      chk("rand_latency", 128'(lat), 128'd10);
      check_keys(ka, "rand");
      e = expand_ref(ka);
      for (int j = 0; j < 6; j++) begin
        rs   = {$urandom, $urandom, $urandom, $urandom};
        rsel = 4'($urandom_range(0, 15));
        apply_sr(rs, rsel, shift_rows_ref(rs) ^ (rsel <= 4'd10 ? rk_of(e, int'(rsel)) : 128'd0),
                 $sformatf("sr_rand_sel%0d", rsel));
      end
    end

    // start during expansion is ignored; a later start restarts
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    do_start(ka);
    lat = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    key_in = kb;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat++;
    wait_done(lat2);
    chk("busy_start_latency", 128'(lat + lat2), 128'd10);
    check_keys(ka, "ignored_start");
    do_start(kb);
    chk("restart_valid_drop", 128'(keys_valid), 128'd0);
    chk("restart_busy", 128'(busy), 128'd1);
    wait_done(lat);
    chk("restart_latency", 128'(lat), 128'd10);
    check_keys(kb, "restart");

    // reset mid-expansion
    ks = {$urandom, $urandom, $urandom, $urandom};
    do_start(ks);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_valid", 128'(keys_valid), 128'd0);
    for (int k = 0; k <= 10; k++) chk($sformatf("midrst_rk%0d", k), rk_of(round_keys, k), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    ka = {$urandom, $urandom, $urandom, $urandom};
    do_start(ka);
    wait_done(lat);
    chk("after_rst_latency", 128'(lat), 128'd10);
    check_keys(ka, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
